// File: rtl/paper_cpu_sequencer_if.sv
// Bus bundle between the paper-CPU sequencer, program memory and the
// register-file/ALU datapath.
interface paper_cpu_sequencer_if #(
  parameter int PC_W = 4
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [7:0]      imem_rdata;
  logic            zero_in;
  logic [1:0]      rf_raddr_a;
  logic [1:0]      rf_raddr_b;
  logic            rf_we;
  logic [1:0]      rf_waddr;
  logic            wdata_sel;
  logic [1:0]      imm;

  // Sequencer side: drives fetch requests and datapath strobes.
  modport master (
    output imem_req, imem_addr, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr,
           wdata_sel, imm,
    input  imem_ack, imem_rdata, zero_in
  );

  // Memory/datapath side.
  modport slave (
    input  imem_req, imem_addr, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr,
           wdata_sel, imm,
    output imem_ack, imem_rdata, zero_in
  );
endinterface

// File: rtl/paper_cpu_sequencer.sv
// Control sequencer for the 2-bit paper processor. Owns pc and ir, fetches
// instructions over a req/ack handshake and steps FETCH -> DECODE -> EXEC.
// A fetch that waits TIMEOUT cycles without ack lands in a sticky FAULT.
module paper_cpu_sequencer #(
  parameter int              PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 8
) (
  input  logic                   clk,
  input  logic                   r_n,
  input  logic                   start,
  paper_cpu_sequencer_if.master  bus,
  output logic                   busy,
  output logic                   halted,
  output logic                   fault
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_LDI  = 2'b01,
    OP_JNZ  = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [TW-1:0]   timer_q, timer_d;
  op_e             op;

  assign op = op_e'(ir_q[7:6]);

  // State, pc, ir and fetch-wait timer registers with async reset.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic; ack on the last allowed fetch cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    timer_d = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          timer_d = '0;
          state_d = S_DECODE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DECODE: begin
        state_d = (op == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (op == OP_JNZ && !bus.zero_in) pc_d = PC_W'(ir_q[3:0]);
        else                              pc_d = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_FETCH;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore strobes from state; field decodes straight from ir.
  always_comb begin
    bus.imem_req   = (state_q == S_FETCH);
    bus.imem_addr  = pc_q;
    bus.rf_we      = (state_q == S_EXEC) && (op == OP_ADD || op == OP_LDI);
    bus.wdata_sel  = (op == OP_LDI);
    bus.rf_raddr_a = ir_q[5:4];
    bus.rf_raddr_b = ir_q[3:2];
    bus.rf_waddr   = ir_q[5:4];
    bus.imm        = ir_q[1:0];
    busy           = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_EXEC);
    halted         = (state_q == S_HALT);
    fault          = (state_q == S_FAULT);
  end

endmodule

// File: tb/tb_paper_cpu_sequencer.sv
// Self-checking bench for paper_cpu_sequencer: an instruction-level
// reference model checked every cycle, plus hand-computed spot checks.
module tb_paper_cpu_sequencer;

  localparam int TIMEOUT = 8;

  logic clk;
  logic r_n;
  logic start;
  logic busy;
  logic halted;
  logic fault;

  int assertCount = 0;
  int failCount   = 0;

  paper_cpu_sequencer_if #(.PC_W(4)) bus ();

  paper_cpu_sequencer #(
    .PC_W     (4),
    .RESET_PC (4'h0),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk    (clk),
    .r_n    (r_n),
    .start  (start),
    .bus    (bus),
    .busy   (busy),
    .halted (halted),
    .fault  (fault)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: where the processor is in its instruction life cycle.
  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_DEC   = 2;
  localparam int PH_EXEC  = 3;
  localparam int PH_HALT  = 4;
  localparam int PH_FAULT = 5;

  int         mPhase  = PH_IDLE;
  int         mPc     = 0;
  logic [7:0] mIr     = 8'h00;
  int         mMissed = 0;

  // Advance the model one clock, or clear it when reset is asserted.
  always @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      mPhase  = PH_IDLE;
      mPc     = 0;
      mIr     = 8'h00;
      mMissed = 0;
    end else begin
      case (mPhase)
        PH_IDLE:  if (start) mPhase = PH_FETCH;
        PH_FETCH: begin
          if (bus.imem_ack) begin
            mIr     = bus.imem_rdata;
            mMissed = 0;
            mPhase  = PH_DEC;
          end else begin
            mMissed = mMissed + 1;
            if (mMissed >= TIMEOUT) mPhase = PH_FAULT;
          end
        end
        PH_DEC:   mPhase = (mIr[7:6] == 2'b11) ? PH_HALT : PH_EXEC;
        PH_EXEC: begin
          if (mIr[7:6] == 2'b10 && !bus.zero_in) mPc = int'(mIr[3:0]);
          else                                   mPc = (mPc + 1) % 16;
          mPhase = PH_FETCH;
        end
        PH_HALT: begin
          if (start) begin
            mPc    = 0;
            mPhase = PH_FETCH;
          end
        end
        default: mPhase = mPhase;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    logic writes;
    writes = (mPhase == PH_EXEC) && (mIr[7:6] == 2'b00 || mIr[7:6] == 2'b01);
    checkOutput("mdlReq",    8'(bus.imem_req),  8'(mPhase == PH_FETCH));
    checkOutput("mdlAddr",   8'(bus.imem_addr), 8'(mPc));
    checkOutput("mdlBusy",   8'(busy),
                8'(mPhase == PH_FETCH || mPhase == PH_DEC || mPhase == PH_EXEC));
    checkOutput("mdlHalted", 8'(halted),        8'(mPhase == PH_HALT));
    checkOutput("mdlFault",  8'(fault),         8'(mPhase == PH_FAULT));
    checkOutput("mdlWe",     8'(bus.rf_we),     8'(writes));
    if (mPhase == PH_DEC || mPhase == PH_EXEC) begin
      checkOutput("mdlRaddrA", 8'(bus.rf_raddr_a), 8'(mIr[5:4]));
      checkOutput("mdlRaddrB", 8'(bus.rf_raddr_b), 8'(mIr[3:2]));
      checkOutput("mdlWaddr",  8'(bus.rf_waddr),   8'(mIr[5:4]));
      checkOutput("mdlImm",    8'(bus.imm),        8'(mIr[1:0]));
    end
    if (writes) checkOutput("mdlSel", 8'(bus.wdata_sel), 8'(mIr[7:6] == 2'b01));
  end

  // Drive one cycle of inputs at a falling edge and wait for the next one.
  task automatic applyStimulus(input logic s, input logic ack,
                               input logic [7:0] data, input logic z);
    start          = s;
    bus.imem_ack   = ack;
    bus.imem_rdata = data;
    bus.zero_in    = z;
    @(negedge clk);
  endtask

  // From FETCH: wait, ack, decode and (unless HALT) execute back to FETCH.
  task automatic runInstr(input logic [7:0] instr, input int waits,
                          input logic z);
    for (int i = 0; i < waits; i++) applyStimulus(1'b0, 1'b0, 8'h00, z);
    applyStimulus(1'b0, 1'b1, instr, z);
    applyStimulus(1'b0, 1'b0, 8'h00, z);
    if (instr[7:6] != 2'b11) applyStimulus(1'b0, 1'b0, 8'h00, z);
  endtask

  // Directed sequence following the instruction test plan.
  initial begin
    start = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = 8'h00; bus.zero_in = 1'b0;
    r_n = 1'b1;
    #1 r_n = 1'b0;
    @(negedge clk);
    checkOutput("resetReq",  8'(bus.imem_req),  8'h00);
    checkOutput("resetAddr", 8'(bus.imem_addr), 8'h00);
    checkOutput("resetBusy", 8'(busy),          8'h00);
    checkOutput("resetWe",   8'(bus.rf_we),     8'h00);
    r_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("fetchReq",  8'(bus.imem_req), 8'h01);
    checkOutput("fetchBusy", 8'(busy),         8'h01);

    // LDI r1,2
    applyStimulus(1'b0, 1'b1, 8'h52, 1'b0);
    checkOutput("ldiDecWe",   8'(bus.rf_we),     8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("ldiWe",      8'(bus.rf_we),     8'h01);
    checkOutput("ldiWaddr",   8'(bus.rf_waddr),  8'h01);
    checkOutput("ldiSel",     8'(bus.wdata_sel), 8'h01);
    checkOutput("ldiImm",     8'(bus.imm),       8'h02);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("ldiNextPc",  8'(bus.imem_addr), 8'h01);
    checkOutput("ldiWeDrop",  8'(bus.rf_we),     8'h00);

    // ADD r1,r2
    applyStimulus(1'b0, 1'b1, 8'h18, 1'b0);
    checkOutput("addRaddrA",  8'(bus.rf_raddr_a), 8'h01);
    checkOutput("addRaddrB",  8'(bus.rf_raddr_b), 8'h02);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("addWe",      8'(bus.rf_we),     8'h01);
    checkOutput("addSel",     8'(bus.wdata_sel), 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("addNextPc",  8'(bus.imem_addr), 8'h02);

    // JNZ r1,0xA taken, after one fetch wait cycle
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("waitAddr",   8'(bus.imem_addr), 8'h02);
    applyStimulus(1'b0, 1'b1, 8'h9A, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("jnzWe",      8'(bus.rf_we),     8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("jnzTaken",   8'(bus.imem_addr), 8'h0A);

    // JNZ not taken, then walk pc up to 0xF and wrap
    runInstr(8'h9A, 0, 1'b1);
    checkOutput("jnzFall",    8'(bus.imem_addr), 8'h0B);
    for (int i = 0; i < 4; i++) runInstr(8'h40 | 8'(i), 0, 1'b0);
    checkOutput("preWrap",    8'(bus.imem_addr), 8'h0F);
    runInstr(8'h53, 0, 1'b0);
    checkOutput("wrapPc",     8'(bus.imem_addr), 8'h00);

    // HALT at pc 1, stray ack, restart with start held
    runInstr(8'h52, 0, 1'b0);
    runInstr(8'hC0, 0, 1'b0);
    checkOutput("haltFlag",   8'(halted),        8'h01);
    checkOutput("haltBusy",   8'(busy),          8'h00);
    checkOutput("haltPc",     8'(bus.imem_addr), 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h52, 1'b0);
    checkOutput("haltStay",   8'(halted),        8'h01);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("restartPc",  8'(bus.imem_addr), 8'h00);
    checkOutput("restartReq", 8'(bus.imem_req),  8'h01);
    applyStimulus(1'b1, 1'b1, 8'h52, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("restartNext", 8'(bus.imem_addr), 8'h01);

    // Timeout: eight fetch cycles without ack
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("preFault",   8'(fault),        8'h00);
    checkOutput("preFaultReq", 8'(bus.imem_req), 8'h01);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("faultSet",   8'(fault),        8'h01);
    checkOutput("faultReq",   8'(bus.imem_req), 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h52, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("faultSticky", 8'(fault),       8'h01);

    // Reset out of FAULT, then ack on the eighth fetch cycle
    #2 r_n = 1'b0;
    @(negedge clk);
    r_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h52, 1'b0);
    checkOutput("lateAckFault", 8'(fault), 8'h00);
    checkOutput("lateAckBusy",  8'(busy),  8'h01);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("lateAckPc", 8'(bus.imem_addr), 8'h01);

    // Asynchronous reset in the middle of a FETCH dwell
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    #2 r_n = 1'b0;
    #1;
    checkOutput("midRstReq",  8'(bus.imem_req),  8'h00);
    checkOutput("midRstAddr", 8'(bus.imem_addr), 8'h00);
    checkOutput("midRstBusy", 8'(busy),          8'h00);
    @(negedge clk);
    r_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h52, 1'b0);
    checkOutput("idleAfterRst", 8'(bus.imem_req), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
